// File: rtl/rst_decipher.sv
// RST cipher decryption: latches and validates a 12-character key, rebuilds the
// 7x7 substitution square, and decodes (row, column) ciphertext pairs.
module rst_decipher (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [95:0] key_char,
  input  logic        key_load,
  output logic        key_ready,
  output logic        err_repeated_char,
  output logic        err_invalid_key_char,
  input  logic        din_valid,
  input  logic [7:0]  din,
  output logic        dout_valid,
  output logic [7:0]  dout,
  output logic        err_invalid_cipher_char
);

  localparam int unsigned KEY_LEN = 12;
  localparam int unsigned CHAR_W  = 8;
  localparam int unsigned KEY_W   = KEY_LEN * CHAR_W;
  localparam int unsigned IDX_W   = 4;
  localparam int unsigned SIDE    = 6;
  localparam int unsigned POS_W   = 3;
  localparam int unsigned CELL_W  = 6;

  // Key positions feeding the row and column headers of the square.
  localparam logic [IDX_W-1:0] ROW_KEY [SIDE] = '{4'd0, 4'd10, 4'd2, 4'd8, 4'd4, 4'd6};
  localparam logic [IDX_W-1:0] COL_KEY [SIDE] = '{4'd1, 4'd11, 4'd3, 4'd9, 4'd5, 4'd7};
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(KEY_LEN - 1);

  typedef enum logic [1:0] {IDLE, KEY_CHECK, READY, KEY_ERR} state_e;
  typedef enum logic {PH_ROW, PH_COL} phase_e;

  state_e              state_q, state_d;
  phase_e              phase_q, phase_d;
  logic [KEY_W-1:0]    key_q, key_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [CHAR_W-1:0]   row_char_q, row_char_d;
  logic                key_ready_q, key_ready_d;
  logic                err_rep_q, err_rep_d;
  logic                err_inv_q, err_inv_d;
  logic                dout_valid_q, dout_valid_d;
  logic [CHAR_W-1:0]   dout_q, dout_d;
  logic                err_cipher_q, err_cipher_d;

  logic [CHAR_W-1:0]   key_bytes [KEY_LEN];
  logic [CHAR_W-1:0]   cur_char;
  logic                char_bad;
  logic                char_dup;
  logic                row_hit, col_hit;
  logic [POS_W-1:0]    row_pos, col_pos;
  logic [CELL_W-1:0]   cell_n;
  logic [CHAR_W-1:0]   cell_char;

  // Key character validation and square lookup datapath.
  always_comb begin
    for (int i = 0; i < KEY_LEN; i++) begin
      key_bytes[i] = key_q[CHAR_W*i +: CHAR_W];
    end
    cur_char = key_bytes[idx_q];
    char_bad = !(((cur_char >= 8'h30) && (cur_char <= 8'h39)) ||
                 ((cur_char >= 8'h41) && (cur_char <= 8'h5A)) ||
                 ((cur_char >= 8'h61) && (cur_char <= 8'h7A)));
    char_dup = 1'b0;
    for (int j = 0; j < KEY_LEN; j++) begin
      if ((IDX_W'(j) < idx_q) && (key_bytes[j] == cur_char)) char_dup = 1'b1;
    end

    row_hit = 1'b0;
    row_pos = '0;
    col_hit = 1'b0;
    col_pos = '0;
    for (int r = 0; r < SIDE; r++) begin
      if (!row_hit && (key_bytes[ROW_KEY[r]] == row_char_q)) begin
        row_hit = 1'b1;
        row_pos = POS_W'(r);
      end
      if (!col_hit && (key_bytes[COL_KEY[r]] == din)) begin
        col_hit = 1'b1;
        col_pos = POS_W'(r);
      end
    end
    cell_n    = CELL_W'(row_pos) * CELL_W'(SIDE) + CELL_W'(col_pos);
    cell_char = (cell_n < CELL_W'(26)) ? (8'h61 + CHAR_W'(cell_n))
                                       : (8'h30 + CHAR_W'(cell_n - CELL_W'(26)));
  end

  // Next-state and output logic.
  always_comb begin
    state_d      = state_q;
    phase_d      = phase_q;
    key_d        = key_q;
    idx_d        = idx_q;
    row_char_d   = row_char_q;
    key_ready_d  = key_ready_q;
    err_rep_d    = err_rep_q;
    err_inv_d    = err_inv_q;
    dout_valid_d = 1'b0;
    dout_d       = dout_q;
    err_cipher_d = 1'b0;

    if (key_load) begin
      key_d       = key_char;
      err_rep_d   = 1'b0;
      err_inv_d   = 1'b0;
      key_ready_d = 1'b0;
      phase_d     = PH_ROW;
      idx_d       = '0;
      state_d     = KEY_CHECK;
    end else begin
      case (state_q)
        KEY_CHECK: begin
          err_rep_d = err_rep_q | char_dup;
          err_inv_d = err_inv_q | char_bad;
          if (idx_q == LAST_IDX) begin
            if (err_rep_d || err_inv_d) begin
              state_d = KEY_ERR;
            end else begin
              state_d     = READY;
              key_ready_d = 1'b1;
            end
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
        READY: begin
          if (din_valid) begin
            if (phase_q == PH_ROW) begin
              row_char_d = din;
              phase_d    = PH_COL;
            end else begin
              phase_d      = PH_ROW;
              dout_valid_d = 1'b1;
              if (row_hit && col_hit) begin
                dout_d = cell_char;
              end else begin
                dout_d       = '0;
                err_cipher_d = 1'b1;
              end
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      phase_q      <= PH_ROW;
      key_q        <= '0;
      idx_q        <= '0;
      row_char_q   <= '0;
      key_ready_q  <= 1'b0;
      err_rep_q    <= 1'b0;
      err_inv_q    <= 1'b0;
      dout_valid_q <= 1'b0;
      dout_q       <= '0;
      err_cipher_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      phase_q      <= phase_d;
      key_q        <= key_d;
      idx_q        <= idx_d;
      row_char_q   <= row_char_d;
      key_ready_q  <= key_ready_d;
      err_rep_q    <= err_rep_d;
      err_inv_q    <= err_inv_d;
      dout_valid_q <= dout_valid_d;
      dout_q       <= dout_d;
      err_cipher_q <= err_cipher_d;
    end
  end

  assign key_ready               = key_ready_q;
  assign err_repeated_char       = err_rep_q;
  assign err_invalid_key_char    = err_inv_q;
  assign dout_valid              = dout_valid_q;
  assign dout                    = dout_q;
  assign err_invalid_cipher_char = err_cipher_q;

endmodule

// File: tb/tb_rst_decipher.sv
// Directed self-checking bench for rst_decipher: key validation, pair decoding,
// error paths, half-pair discard on key reload and asynchronous reset.
module tb_rst_decipher;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [95:0] key_char;
  logic        key_load;
  logic        key_ready;
  logic        err_repeated_char;
  logic        err_invalid_key_char;
  logic        din_valid;
  logic [7:0]  din;
  logic        dout_valid;
  logic [7:0]  dout;
  logic        err_invalid_cipher_char;

  int checks = 0;
  int errors = 0;

  localparam logic [95:0] KEY_GOOD = "abcdefghilmn";
  localparam logic [95:0] KEY_DUP  = "abcdefghilma";
  localparam logic [95:0] KEY_BAD  = "abcdefghilm!";

  rst_decipher dut (
    .clk                     (clk),
    .rst_n                   (rst_n),
    .key_char                (key_char),
    .key_load                (key_load),
    .key_ready               (key_ready),
    .err_repeated_char       (err_repeated_char),
    .err_invalid_key_char    (err_invalid_key_char),
    .din_valid               (din_valid),
    .din                     (din),
    .dout_valid              (dout_valid),
    .dout                    (dout),
    .err_invalid_cipher_char (err_invalid_cipher_char)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Pulse key_load with the given key; returns just after the sampling edge.
  task automatic load_key(input logic [95:0] k);
    key_char = k;
    key_load = 1'b1;
    tick();
    key_load = 1'b0;
  endtask

  task automatic send_char(input logic [7:0] c);
    din_valid = 1'b1;
    din       = c;
    tick();
    din_valid = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; key_load = 1'b0; key_char = '0; din_valid = 1'b0; din = '0;
    repeat (2) tick();
    checks++;
    if ({key_ready, err_repeated_char, err_invalid_key_char, dout_valid, dout,
         err_invalid_cipher_char} !== 13'h0) begin
      errors++;
      $display("FAIL reset_outputs: got kr=%b rep=%b inv=%b dv=%b dout=%h ec=%b, want all 0",
               key_ready, err_repeated_char, err_invalid_key_char, dout_valid, dout,
               err_invalid_cipher_char);
    end
    #3 rst_n = 1'b1;
    tick();
  endtask

  task automatic test_key_load;
    int early;
    load_key(KEY_GOOD);
    early = 0;
    for (int c = 1; c <= 11; c++) begin
      if (key_ready !== 1'b0) early++;
      tick();
    end
    if (key_ready !== 1'b0) early++;
    checks++;
    if (early != 0) begin
      errors++;
      $display("FAIL key_ready_early: high on %0d of cycles 0..11, want 0", early);
    end
    tick();
    checks++;
    if (key_ready !== 1'b1) begin
      errors++;
      $display("FAIL key_ready_at_12: got %b want 1", key_ready);
    end
    checks++;
    if ({err_repeated_char, err_invalid_key_char} !== 2'b00) begin
      errors++;
      $display("FAIL good_key_flags: got rep=%b inv=%b want 0 0",
               err_repeated_char, err_invalid_key_char);
    end
  endtask

  task automatic test_decode;
    logic [7:0] stream [8] = '{"n", "m", "b", "a", "l", "i", "f", "e"};
    logic [7:0] expect_c [4] = '{"a", "h", "o", "9"};
    for (int p = 0; p < 4; p++) begin
      din_valid = 1'b1;
      din = stream[2*p];
      tick();
      checks++;
      if (dout_valid !== 1'b0) begin
        errors++;
        $display("FAIL decode_row_phase%0d: dout_valid got %b want 0", p, dout_valid);
      end
      din = stream[2*p+1];
      tick();
      checks++;
      if (dout_valid !== 1'b1 || dout !== expect_c[p] || err_invalid_cipher_char !== 1'b0) begin
        errors++;
        $display("FAIL decode_pair%0d: got dv=%b dout=%h ec=%b want dv=1 dout=%h ec=0",
                 p, dout_valid, dout, err_invalid_cipher_char, expect_c[p]);
      end
    end
    din_valid = 1'b0;
    tick();
    checks++;
    if (dout_valid !== 1'b0 || dout !== 8'h39) begin
      errors++;
      $display("FAIL decode_hold: got dv=%b dout=%h want dv=0 dout=39", dout_valid, dout);
    end
  endtask

  task automatic test_invalid_pair;
    send_char("z");
    send_char("m");
    checks++;
    if (dout_valid !== 1'b1 || dout !== 8'h00 || err_invalid_cipher_char !== 1'b1) begin
      errors++;
      $display("FAIL bad_pair: got dv=%b dout=%h ec=%b want dv=1 dout=00 ec=1",
               dout_valid, dout, err_invalid_cipher_char);
    end
    send_char("n");
    checks++;
    if (err_invalid_cipher_char !== 1'b0 || dout_valid !== 1'b0) begin
      errors++;
      $display("FAIL bad_pair_pulse: got dv=%b ec=%b want 0 0", dout_valid,
               err_invalid_cipher_char);
    end
    send_char("m");
    checks++;
    if (dout_valid !== 1'b1 || dout !== "a" || err_invalid_cipher_char !== 1'b0) begin
      errors++;
      $display("FAIL resync_pair: got dv=%b dout=%h ec=%b want dv=1 dout=61 ec=0",
               dout_valid, dout, err_invalid_cipher_char);
    end
  endtask

  task automatic test_key_errors;
    int seen_dv;
    load_key(KEY_DUP);
    repeat (12) tick();
    checks++;
    if (err_repeated_char !== 1'b1 || err_invalid_key_char !== 1'b0 || key_ready !== 1'b0) begin
      errors++;
      $display("FAIL dup_key: got rep=%b inv=%b kr=%b want 1 0 0",
               err_repeated_char, err_invalid_key_char, key_ready);
    end
    seen_dv = 0;
    din_valid = 1'b1;
    foreach (KEY_GOOD[i]) begin end
    din = "n"; tick(); if (dout_valid !== 1'b0) seen_dv++;
    din = "m"; tick(); if (dout_valid !== 1'b0) seen_dv++;
    din_valid = 1'b0;
    tick(); if (dout_valid !== 1'b0) seen_dv++;
    checks++;
    if (seen_dv != 0 || key_ready !== 1'b0 || err_repeated_char !== 1'b1) begin
      errors++;
      $display("FAIL key_err_ignore: dv seen %0d times kr=%b rep=%b want 0 0 1",
               seen_dv, key_ready, err_repeated_char);
    end
    load_key(KEY_BAD);
    checks++;
    if (err_repeated_char !== 1'b0) begin
      errors++;
      $display("FAIL flag_clear_on_load: rep got %b want 0", err_repeated_char);
    end
    repeat (12) tick();
    checks++;
    if (err_invalid_key_char !== 1'b1 || err_repeated_char !== 1'b0 || key_ready !== 1'b0) begin
      errors++;
      $display("FAIL bad_char_key: got inv=%b rep=%b kr=%b want 1 0 0",
               err_invalid_key_char, err_repeated_char, key_ready);
    end
  endtask

  task automatic test_half_pair;
    load_key(KEY_GOOD);
    repeat (12) tick();
    send_char("n");
    // key_load collides with the would-be column character, which must be dropped
    din_valid = 1'b1;
    din       = "m";
    load_key(KEY_GOOD);
    din_valid = 1'b0;
    checks++;
    if (dout_valid !== 1'b0 || key_ready !== 1'b0) begin
      errors++;
      $display("FAIL collide_drop: got dv=%b kr=%b want 0 0", dout_valid, key_ready);
    end
    repeat (12) tick();
    checks++;
    if (key_ready !== 1'b1) begin
      errors++;
      $display("FAIL reload_ready: got %b want 1", key_ready);
    end
    send_char("b");
    send_char("a");
    checks++;
    if (dout_valid !== 1'b1 || dout !== "h" || err_invalid_cipher_char !== 1'b0) begin
      errors++;
      $display("FAIL after_discard: got dv=%b dout=%h ec=%b want dv=1 dout=68 ec=0",
               dout_valid, dout, err_invalid_cipher_char);
    end
  endtask

  task automatic test_async_reset;
    int bad;
    send_char("n");
    send_char("m");
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({key_ready, err_repeated_char, err_invalid_key_char, dout_valid, dout,
         err_invalid_cipher_char} !== 13'h0) begin
      errors++;
      $display("FAIL async_reset: got kr=%b dv=%b dout=%h ec=%b want all 0",
               key_ready, dout_valid, dout, err_invalid_cipher_char);
    end
    tick();
    #3 rst_n = 1'b1;
    tick();
    bad = 0;
    for (int i = 0; i < 4; i++) begin
      send_char((i % 2 == 0) ? 8'h6E : 8'h6D);
      if (key_ready !== 1'b0 || dout_valid !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL post_reset_idle: %0d cycles with kr or dv high, want 0", bad);
    end
  endtask

  initial begin
    test_reset();
    test_key_load();
    test_decode();
    test_invalid_pair();
    test_key_errors();
    test_half_pair();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/rst_decipher.md
Name: rst_decipher

Overview:
- Decryption end of the RST substitution cipher. It latches and validates a 12-character key, then rebuilds the same 7x7 substitution square that `init_table` builds for encryption.
- It consumes a ciphertext stream of character pairs (row header, column header) and emits one plaintext character per pair.
- It sits downstream of the link that carries ciphertext produced by the encryption path.

Parameters:
- None. Key length (12), square size (7x7) and alphabet are fixed by the cipher definition.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- key_char  input  96  key; k[i] = key_char[8*i+7 : 8*i], i = 0..11.
- key_load  input  1  1-cycle pulse; latches key_char and starts validation.
- key_ready  output  1  high while a valid key is loaded and ciphertext is accepted.
- err_repeated_char  output  1  sticky: key contains a duplicated character.
- err_invalid_key_char  output  1  sticky: key contains a character outside [A-Za-z0-9].
- din_valid  input  1  ciphertext character strobe.
- din  input  8  ciphertext character.
- dout_valid  output  1  1-cycle plaintext strobe.
- dout  output  8  plaintext character.
- err_invalid_cipher_char  output  1  1-cycle pulse, aligned with dout_valid, when a pair fails lookup.

Behaviour:
- Reset (async, rst_n=0): all outputs 0, state IDLE, latched key = 0, pair phase = ROW, check index = 0.
- Square definition:
  - [0][0] = 8'h00.
  - Row headers r1..r6 = k0, k10, k2, k8, k4, k6.
  - Column headers c1..c6 = k1, k11, k3, k9, k5, k7.
  - Interior cell (r,c), r,c in 1..6: index n = 6*(r-1)+(c-1).
  - n = 0..25 maps to 'a'+n; n = 26..35 maps to '0'+(n-26).
- FSM states: IDLE, KEY_CHECK, READY, KEY_ERR.
  - key_load=1 in any state:
    - latch key_char;
    - clear both error flags and key_ready;
    - discard any half-received pair; phase = ROW;
    - enter KEY_CHECK with index = 0.
  - KEY_CHECK: one key character per cycle, index 0..11.
    - Set err_invalid_key_char if k[index] is not in 0x30-0x39, 0x41-0x5A or 0x61-0x7A.
    - Set err_repeated_char if k[index] equals any k[j] with j < index.
    - After index 11, go to READY if neither flag is set, else KEY_ERR.
    - key_ready rises exactly 12 cycles after the edge that sampled key_load.
  - READY: key_ready=1; din is accepted on every cycle with din_valid=1 (no backpressure).
    - Phase ROW: store din as the row character; phase -> COL.
    - Phase COL: look up stored row character among r1..r6 and din among c1..c6 (exact 8-bit, case-sensitive match); phase -> ROW.
  - KEY_ERR: key_ready=0, flags held, din ignored until the next key_load.
  - IDLE and KEY_CHECK: din_valid ignored.
- Output timing:
  - dout and dout_valid are registered and appear 1 cycle after the COL character is accepted.
  - Both lookups hit: dout = cell character, err_invalid_cipher_char = 0.
  - Either lookup misses: dout = 8'h00, err_invalid_cipher_char = 1.
  - dout holds its last value when dout_valid = 0.
- Back-to-back pairs: din_valid may be high every cycle, giving at most one plaintext per 2 input cycles.
- key_load and din_valid in the same cycle: key_load wins and din is dropped.
- A dout_valid already in flight for a pair completed before key_load is still delivered.

Test Plan:
- key_char="abcdefghilmn" (k0='n', k11='a'), key_load pulse -> key_ready=1 exactly 12 cycles later, both error flags 0; rows = n,b,l,d,h,f; columns = m,a,i,c,g,e.
- With that key, din stream 'n','m','b','a','l','i','f','e' on consecutive cycles -> dout 'a','h','o','9', each one cycle after its second character, err_invalid_cipher_char=0.
- Pair 'z','m' -> dout=8'h00 with err_invalid_cipher_char=1; the next pair 'n','m' still decodes to 'a' (phase resynchronised).
- key "abcdefghilma" -> err_repeated_char=1, key_ready stays 0, din ignored; key "abcdefghilm!" -> err_invalid_key_char=1.
- Send 'n' only, then pulse key_load with the valid key -> half-pair discarded; after key_ready, 'b','a' -> 'h'.
- Assert rst_n=0 mid-stream -> all outputs 0 immediately (asynchronously); after release, key_ready stays 0 until a new key_load.
